// File: rtl/game_result_logger.sv
// Logs one {who, length, count} record per counter game end into a small FIFO and tracks a best-of match score.
// Record visible one cycle after the event; FIFO drains over valid/ready and drops new records when full and not popped.

module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [W-1:0]     wr_dat,
  input  logic             rd_rdy,
  output logic [W-1:0]     rd_dat,
  output logic [LVL_W-1:0] level
);
  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;

  // Callers only assert wr_vld with room (or a same-cycle pop) and rd_rdy when non-empty.
  always_ff @(posedge clk) begin
    if (wr_vld) mem_q[wr_ptr_q] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_vld) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_rdy) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({wr_vld, rd_rdy})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign rd_dat = mem_q[rd_ptr_q];
  assign level  = level_q;
endmodule

module game_result_logger #(
  parameter int COUNT_W    = 5,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int MATCH_WINS = 3,
  localparam int LVL_W     = $clog2(FIFO_DEPTH + 1),
  localparam int SCORE_W   = $clog2(MATCH_WINS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COUNT_W-1:0] count_in,
  input  logic               gameover_in,
  input  logic [1:0]         who_in,
  input  logic               clear,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic [1:0]         rec_who,
  output logic [LEN_W-1:0]   rec_len,
  output logic [COUNT_W-1:0] rec_count,
  output logic [LVL_W-1:0]   fifo_level,
  output logic               overflow,
  output logic [SCORE_W-1:0] score_w,
  output logic [SCORE_W-1:0] score_l,
  output logic               match_done,
  output logic [1:0]         match_winner
);
  localparam int REC_W = 2 + LEN_W + COUNT_W;

  typedef struct packed {
    logic [1:0]         who;
    logic [LEN_W-1:0]   len;
    logic [COUNT_W-1:0] count;
  } rec_t;

  typedef enum logic {PLAYING, DONE} state_t;

  logic               go_q;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overflow_q;
  state_t             state_q;
  logic [SCORE_W-1:0] score_w_q, score_l_q;
  logic [1:0]         winner_q;

  logic event_vld, full, pop, push, drop;
  rec_t wr_rec, head_rec;

  assign event_vld = gameover_in && !go_q;
  assign full      = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign pop       = rec_valid && rec_ready;
  assign push      = event_vld && (!full || pop);
  assign drop      = event_vld && full && !pop;
  assign wr_rec    = '{who: who_in, len: len_q, count: count_in};

  // Length restarts at 1 on an event so later games measure event-to-event spacing.
  always_comb begin
    len_d = len_q;
    if (event_vld)        len_d = LEN_W'(1);
    else if (len_q != '1) len_d = len_q + LEN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      go_q       <= 1'b0;
      len_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      go_q  <= gameover_in;
      len_q <= len_d;
      if (drop) overflow_q <= 1'b1;
    end
  end

  fifo #(.W(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (push),
    .wr_dat (wr_rec),
    .rd_rdy (pop),
    .rd_dat (head_rec),
    .level  (fifo_level)
  );

  // clear overrides any coincident event for scoring; the record itself is still pushed.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q   <= PLAYING;
      score_w_q <= '0;
      score_l_q <= '0;
      winner_q  <= 2'b00;
    end else if (state_q == PLAYING && event_vld) begin
      if (who_in == 2'b10) begin
        score_w_q <= score_w_q + SCORE_W'(1);
        if (score_w_q == SCORE_W'(MATCH_WINS - 1)) begin
          state_q  <= DONE;
          winner_q <= 2'b10;
        end
      end else if (who_in == 2'b01) begin
        score_l_q <= score_l_q + SCORE_W'(1);
        if (score_l_q == SCORE_W'(MATCH_WINS - 1)) begin
          state_q  <= DONE;
          winner_q <= 2'b01;
        end
      end
    end
  end

  assign rec_valid    = (fifo_level != '0);
  assign rec_who      = rec_valid ? head_rec.who   : 2'b00;
  assign rec_len      = rec_valid ? head_rec.len   : '0;
  assign rec_count    = rec_valid ? head_rec.count : '0;
  assign overflow     = overflow_q;
  assign score_w      = score_w_q;
  assign score_l      = score_l_q;
  assign match_done   = (state_q == DONE);
  assign match_winner = winner_q;
endmodule

// File: tb/tb_game_result_logger.sv
// Directed bench for game_result_logger: event detection, lengths, FIFO full/drop, match scoring, clear and reset.

module tb_game_result_logger;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  count_in;
  logic        gameover_in;
  logic [1:0]  who_in;
  logic        clear;
  logic        rec_valid;
  logic        rec_ready;
  logic [1:0]  rec_who;
  logic [15:0] rec_len;
  logic [4:0]  rec_count;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic [1:0]  score_w, score_l;
  logic        match_done;
  logic [1:0]  match_winner;

  int n_chk  = 0;
  int n_fail = 0;

  game_result_logger dut (
    .clk          (clk),
    .rst          (rst),
    .count_in     (count_in),
    .gameover_in  (gameover_in),
    .who_in       (who_in),
    .clear        (clear),
    .rec_valid    (rec_valid),
    .rec_ready    (rec_ready),
    .rec_who      (rec_who),
    .rec_len      (rec_len),
    .rec_count    (rec_count),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .score_w      (score_w),
    .score_l      (score_l),
    .match_done   (match_done),
    .match_winner (match_winner)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle gameover pulse; returns in the cycle after the event with gameover_in low.
  task automatic ev(input logic [1:0] w, input logic [4:0] c);
    gameover_in = 1'b1;
    who_in      = w;
    count_in    = c;
    tick();
    gameover_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; gameover_in = 1'b0; who_in = 2'b00; count_in = '0; clear = 1'b0; rec_ready = 1'b0;
    tick(); tick();
    n_chk++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0d exp 0", rec_valid); end
    n_chk++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
    n_chk++; if ({rec_who, rec_len, rec_count} !== 23'd0) begin n_fail++; $display("FAIL rst_head got %0h exp 0", {rec_who, rec_len, rec_count}); end
    n_chk++; if ({overflow, score_w, score_l, match_done, match_winner} !== 8'd0) begin n_fail++; $display("FAIL rst_state got %0h exp 0", {overflow, score_w, score_l, match_done, match_winner}); end
    rst = 1'b0;
  endtask

  task automatic test_first_games();
    repeat (10) tick();
    ev(2'b10, 5'd31);
    n_chk++; if (rec_valid !== 1'b1) begin n_fail++; $display("FAIL g1_valid got %0d exp 1", rec_valid); end
    n_chk++; if (rec_who !== 2'b10) begin n_fail++; $display("FAIL g1_who got %0b exp 10", rec_who); end
    n_chk++; if (rec_len !== 16'd10) begin n_fail++; $display("FAIL g1_len got %0d exp 10", rec_len); end
    n_chk++; if (rec_count !== 5'd31) begin n_fail++; $display("FAIL g1_count got %0d exp 31", rec_count); end
    n_chk++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL g1_level got %0d exp 1", fifo_level); end
    n_chk++; if (score_w !== 2'd1) begin n_fail++; $display("FAIL g1_score_w got %0d exp 1", score_w); end
    repeat (24) tick();
    gameover_in = 1'b1; who_in = 2'b01; count_in = 5'd0;
    tick(); tick(); tick();
    gameover_in = 1'b0;
    n_chk++; if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL g2_level got %0d exp 2", fifo_level); end
    n_chk++; if (score_l !== 2'd1) begin n_fail++; $display("FAIL g2_score_l got %0d exp 1", score_l); end
    n_chk++; if (rec_who !== 2'b10 || rec_len !== 16'd10) begin n_fail++; $display("FAIL g2_head_stable got %0b/%0d exp 10/10", rec_who, rec_len); end
    rec_ready = 1'b1;
    tick();
    n_chk++; if (rec_who !== 2'b01) begin n_fail++; $display("FAIL g2_who got %0b exp 01", rec_who); end
    n_chk++; if (rec_len !== 16'd25) begin n_fail++; $display("FAIL g2_len got %0d exp 25", rec_len); end
    n_chk++; if (rec_count !== 5'd0) begin n_fail++; $display("FAIL g2_count got %0d exp 0", rec_count); end
    tick();
    n_chk++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid got %0d exp 0", rec_valid); end
    tick();
    n_chk++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL empty_pop_level got %0d exp 0", fifo_level); end
    rec_ready = 1'b0;
  endtask

  task automatic test_overflow();
    int exp_c [4] = '{2, 3, 4, 6};
    for (int i = 1; i <= 5; i++) begin
      ev(2'b00, 5'(i));
      if (i == 4) begin
        n_chk++; if (fifo_level !== 3'd4 || overflow !== 1'b0) begin n_fail++; $display("FAIL ov_fill got %0d/%0d exp 4/0", fifo_level, overflow); end
      end
      if (i == 5) begin
        n_chk++; if (fifo_level !== 3'd4 || overflow !== 1'b1) begin n_fail++; $display("FAIL ov_drop got %0d/%0d exp 4/1", fifo_level, overflow); end
      end
      tick();
    end
    n_chk++; if (score_w !== 2'd1 || score_l !== 2'd1) begin n_fail++; $display("FAIL ov_noscore got %0d/%0d exp 1/1", score_w, score_l); end
    rec_ready = 1'b1;
    ev(2'b00, 5'd6);
    rec_ready = 1'b0;
    n_chk++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ov_pushpop_level got %0d exp 4", fifo_level); end
    n_chk++; if (rec_count !== 5'd2) begin n_fail++; $display("FAIL ov_pushpop_head got %0d exp 2", rec_count); end
    rec_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_chk++; if (rec_count !== 5'(exp_c[k])) begin n_fail++; $display("FAIL ov_order%0d got %0d exp %0d", k, rec_count, exp_c[k]); end
      tick();
    end
    n_chk++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL ov_drained got %0d exp 0", rec_valid); end
  endtask

  task automatic test_match();
    clear = 1'b1; tick(); clear = 1'b0;
    n_chk++; if (score_w !== 2'd0 || score_l !== 2'd0) begin n_fail++; $display("FAIL m_clear0 got %0d/%0d exp 0/0", score_w, score_l); end
    for (int i = 0; i < 3; i++) begin
      ev(2'b10, 5'(i));
      n_chk++; if (score_w !== 2'(i + 1)) begin n_fail++; $display("FAIL m_score_w%0d got %0d exp %0d", i, score_w, i + 1); end
      n_chk++; if (match_done !== (i == 2)) begin n_fail++; $display("FAIL m_done%0d got %0d exp %0d", i, match_done, i == 2); end
      tick();
    end
    n_chk++; if (match_winner !== 2'b10) begin n_fail++; $display("FAIL m_winner got %0b exp 10", match_winner); end
    ev(2'b01, 5'd7);
    n_chk++; if (score_l !== 2'd0 || score_w !== 2'd3) begin n_fail++; $display("FAIL m_frozen got %0d/%0d exp 3/0", score_w, score_l); end
    n_chk++; if (fifo_level !== 3'd1 || rec_who !== 2'b01) begin n_fail++; $display("FAIL m_logged got %0d/%0b exp 1/01", fifo_level, rec_who); end
    tick();
    clear = 1'b1; tick(); clear = 1'b0;
    n_chk++; if ({score_w, score_l, match_done, match_winner} !== 7'd0) begin n_fail++; $display("FAIL m_clear got %0h exp 0", {score_w, score_l, match_done, match_winner}); end
    rec_ready = 1'b0;
  endtask

  task automatic test_clear_and_rst();
    ev(2'b10, 5'd9);
    n_chk++; if (score_w !== 2'd1) begin n_fail++; $display("FAIL c_pre got %0d exp 1", score_w); end
    tick();
    clear = 1'b1;
    ev(2'b10, 5'd10);
    clear = 1'b0;
    n_chk++; if (score_w !== 2'd0 || match_done !== 1'b0) begin n_fail++; $display("FAIL c_wins got %0d/%0d exp 0/0", score_w, match_done); end
    n_chk++; if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL c_pushed got %0d exp 2", fifo_level); end
    tick();
    ev(2'b01, 5'd11);
    n_chk++; if (fifo_level !== 3'd3 || overflow !== 1'b1) begin n_fail++; $display("FAIL r_pre got %0d/%0d exp 3/1", fifo_level, overflow); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_chk++; if (fifo_level !== 3'd0 || rec_valid !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL r_mid got %0d/%0d/%0d exp 0/0/0", fifo_level, rec_valid, overflow); end
    n_chk++; if ({score_w, score_l, rec_who, rec_len} !== 22'd0) begin n_fail++; $display("FAIL r_state got %0h exp 0", {score_w, score_l, rec_who, rec_len}); end
  endtask

  initial begin
    test_reset();
    test_first_games();
    test_overflow();
    test_match();
    test_clear_and_rst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/game_result_logger.md
# game_result_logger

Downstream consumer of the multi-mode counter's game outputs. Detects each game end (rising edge of the counter's one-cycle GAMEOVER pulse), measures game length in clocks, and queues a result record {who, length, final count} in a small FIFO read out over a valid/ready port. Also keeps a best-of match score and flags the match winner.

## Interface

Parameters:
- COUNT_W, 5, width of count_in / rec_count (matches counter size)
- LEN_W, 16, width of game-length counter and rec_len
- FIFO_DEPTH, 4, record FIFO entries (power of two, >= 2)
- MATCH_WINS, 3, game wins needed to take the match
- Derived: LVL_W = $clog2(FIFO_DEPTH+1); SCORE_W = $clog2(MATCH_WINS+1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- count_in  in  COUNT_W  counter value
- gameover_in  in  1  counter GAMEOVER
- who_in  in  2  counter who (10 = max side, 01 = zero side, 00 = none)
- clear  in  1  synchronous match clear (scores/match state only)
- rec_valid  out  1  FIFO head valid
- rec_ready  in  1  consumer accepts head
- rec_who  out  2  head record: who
- rec_len  out  LEN_W  head record: game length in cycles
- rec_count  out  COUNT_W  head record: count_in at event
- fifo_level  out  LVL_W  entries held
- overflow  out  1  sticky: record dropped
- score_w / score_l  out  SCORE_W each  games won by max side / zero side
- match_done  out  1  match decided
- match_winner  out  2  10 / 01 when match_done, else 00

## Operation

- Event: gameover_in==1 && go_d==0, go_d = gameover_in registered (reset 0). gameover_in high in first post-reset cycle is an event. Held-high gameover_in gives one event only.
- Length counter len_cnt: reset 0; non-event cycle: len_cnt+1, saturating at 2^LEN_W-1; event cycle: record len_cnt, load 1. First game length = cycles since reset release (first post-reset cycle = 0); later games = cycles between event cycles.
- Record on event: {who_in, len_cnt, count_in} sampled in the event cycle; who_in=00 is logged as-is and scores nothing.
- FIFO: push on event, pop on rec_valid && rec_ready. rec_valid = (fifo_level != 0). No fall-through.
  - Full, push, no pop: record dropped, overflow <= 1 (cleared only by rst), level stays FIFO_DEPTH.
  - Full, push and pop same cycle: both happen, level unchanged, no overflow.
  - Empty, rec_ready high: nothing popped; level never underflows.
  - Head outputs stable while rec_valid && !rec_ready.
- Match FSM, states PLAYING, DONE:
  - PLAYING: event with who=10 -> score_w+1; who=01 -> score_l+1. Score reaching MATCH_WINS -> DONE, match_winner = 10 or 01.
  - DONE: scores frozen, match_done=1; events still logged to FIFO.
  - clear (any state): scores 0, match_winner 00, -> PLAYING. clear with event same cycle: clear wins for scores/FSM; record still pushed.
- rst mid-operation: FIFO emptied, in-flight records lost, all state to reset values.

## Timing

- Reset values: rec_valid 0, rec_who/rec_len/rec_count 0, fifo_level 0, overflow 0, score_w/score_l 0, match_done 0, match_winner 00, FSM PLAYING, len_cnt 0, go_d 0.
- Event cycle T (gameover_in rises at T): record written at edge ending T; rec_valid=1 and fifo_level+1 in T+1 (empty FIFO case).
- Pop: handshake in cycle P -> next head (or rec_valid=0) in P+1.
- Score update and match_done/match_winner visible in T+1.
- overflow asserts in cycle after the dropped push.

## Test plan

- Reset, gameover_in pulse at post-reset cycle 10 with who=10, count_in=31, rec_ready=0 -> cycle 11: rec_valid=1, rec_who=10, rec_len=10, rec_count=31, fifo_level=1, score_w=1.
- Second pulse 25 cycles after first, who=01, count_in=0 -> rec_len=25 in second entry, score_l=1; gameover_in held high 3 cycles -> only one record.
- 5 events with rec_ready=0, FIFO_DEPTH=4 -> fifo_level=4, overflow=1 after 5th; then full+push with rec_ready=1 same cycle -> level stays 4, no new drop.
- Three who=10 wins -> match_done=1, match_winner=10 cycle after third; further who=01 events -> score_l frozen, records still logged; clear -> scores 0, match_done=0.
- clear coincident with who=10 event -> score_w=0, record pushed; rst asserted with fifo_level=3 -> next cycle fifo_level=0, rec_valid=0, overflow=0.
